// File: rtl/countdown_timer.sv
// Loadable down-counter timer: counts a loaded value down to zero, pulses done, then idles or auto-reloads.
// Latency: start with value N shows count=N after that edge and done (count=0) N edges later; zero-length start gives done after one edge.
// Backpressure: load_ready is high only in IDLE; load/start are ignored while the timer is RUN or DONE.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   load_valid/load_value   load handshake (accepted when load_valid && load_ready)
//   load_ready              high only in IDLE
//   start, pause, stop      run control (start in IDLE, pause/stop in RUN, stop in DONE)
//   auto_reload             sampled in DONE: rerun from the reload value when non-zero
//   count, busy, done       current count, RUN/DONE indication, one-cycle terminal pulse
//   expire_cnt              wrapping tally of done pulses since reset
module countdown_timer #(
    parameter int WIDTH = 16,
    parameter int EXP_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [EXP_W-1:0] expire_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] start_value;

    // A load presented in the same cycle as start takes effect immediately.
    assign start_value = load_valid ? load_value : reload_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            expire_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        reload_reg <= load_value;
                        count      <= load_value;
                    end
                    if (start) begin
                        if (start_value != '0) begin
                            state <= RUN;
                            count <= start_value;
                        end else begin
                            // Zero-length timer: straight to DONE so it still pulses once.
                            state      <= DONE;
                            count      <= '0;
                            expire_cnt <= expire_cnt + 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (stop) begin
                        // Abort keeps the current count visible; no done, no tally.
                        state <= IDLE;
                    end else if (!pause) begin
                        // RUN is only entered with a non-zero count, so <= ONE is
                        // the terminal step; counting never goes below zero.
                        if (count <= ONE) begin
                            count      <= '0;
                            state      <= DONE;
                            expire_cnt <= expire_cnt + 1'b1;
                        end else begin
                            count <= count - ONE;
                        end
                    end
                end

                DONE: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (auto_reload && reload_reg != '0) begin
                        state <= RUN;
                        count <= reload_reg;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Status outputs decode straight from the registered state.
    assign load_ready = (state == IDLE);
    assign busy       = (state == RUN) || (state == DONE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int WIDTH = 16;
    localparam int EXP_W = 8;

    logic             clock;
    logic             reset;
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             load_ready;
    logic             start;
    logic             pause;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [EXP_W-1:0] expire_cnt;

    countdown_timer #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_value  (load_value),
        .load_ready  (load_ready),
        .start       (start),
        .pause       (pause),
        .stop        (stop),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .expire_cnt  (expire_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string tag;
        int    cnt;
        bit    dn;
        bit    bs;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected per-cycle outputs; load_ready must be the complement of busy.
    task automatic push(input string tag, input int cnt, input bit dn, input bit bs);
        exp_t e;
        e.tag = tag;
        e.cnt = cnt;
        e.dn  = dn;
        e.bs  = bs;
        sb.push_back(e);
    endtask

    // Countdown from..to inclusive while in RUN.
    task automatic push_run(input string tag, input int from, input int to);
        for (int v = from; v >= to; v--) push(tag, v, 1'b0, 1'b1);
    endtask

    // Advance n clocks; after each edge pop one expectation and compare.
    task automatic run_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_underrun", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_count"}, 32'(count), 32'(e.cnt));
                chk({e.tag, "_done"},  32'(done),  32'(e.dn));
                chk({e.tag, "_busy"},  32'(busy),  32'(e.bs));
                chk({e.tag, "_ldrdy"}, 32'(load_ready), 32'(!e.bs));
            end
        end
    endtask

    // Drain whatever has been queued.
    task automatic drain();
        run_cycles(sb.size());
    endtask

    initial begin
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_value  = '0;
        start       = 1'b0;
        pause       = 1'b0;
        stop        = 1'b0;
        auto_reload = 1'b0;

        // 1: reset then idle
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) push("t1_idle", 0, 1'b0, 1'b0);
        drain();
        chk("t1_expire", 32'(expire_cnt), 32'd0);

        // 2: load 5, start, no auto-reload
        load_valid = 1'b1; load_value = 16'd5;
        push("t2_load", 5, 1'b0, 1'b0);
        drain();
        load_valid = 1'b0; start = 1'b1;
        push("t2_e0", 5, 1'b0, 1'b1);
        run_cycles(1);
        start = 1'b0;
        push_run("t2_run", 4, 1);
        push("t2_done", 0, 1'b1, 1'b1);
        push("t2_idle", 0, 1'b0, 1'b0);
        drain();
        chk("t2_expire", 32'(expire_cnt), 32'd1);

        // 3: load 3 with auto-reload; three pulses in 12 cycles
        auto_reload = 1'b1;
        load_valid = 1'b1; load_value = 16'd3;
        push("t3_load", 3, 1'b0, 1'b0);
        drain();
        load_valid = 1'b0; start = 1'b1;
        push("t3_e0", 3, 1'b0, 1'b1);
        run_cycles(1);
        start = 1'b0;
        push_run("t3_run", 2, 1);
        push("t3_done", 0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            push_run("t3_rerun", 3, 1);
            push("t3_done", 0, 1'b1, 1'b1);
        end
        drain();
        chk("t3_expire", 32'(expire_cnt), 32'd4);
        auto_reload = 1'b0;
        push("t3_idle", 0, 1'b0, 1'b0);
        drain();

        // 4: load 10, pause 4 cycles at count 6
        load_valid = 1'b1; load_value = 16'd10;
        push("t4_load", 10, 1'b0, 1'b0);
        drain();
        load_valid = 1'b0; start = 1'b1;
        push("t4_e0", 10, 1'b0, 1'b1);
        run_cycles(1);
        start = 1'b0;
        push_run("t4_run", 9, 6);
        drain();
        pause = 1'b1;
        for (int i = 0; i < 4; i++) push("t4_pause", 6, 1'b0, 1'b1);
        drain();
        pause = 1'b0;
        push_run("t4_resume", 5, 1);
        push("t4_done", 0, 1'b1, 1'b1);
        push("t4_idle", 0, 1'b0, 1'b0);
        drain();
        chk("t4_expire", 32'(expire_cnt), 32'd5);

        // 5: load 8, stop at 2; load/start during RUN ignored; rerun, stop at 1
        load_valid = 1'b1; load_value = 16'd8;
        push("t5_load", 8, 1'b0, 1'b0);
        drain();
        load_valid = 1'b0; start = 1'b1;
        push("t5_e0", 8, 1'b0, 1'b1);
        run_cycles(1);
        start = 1'b0;
        load_valid = 1'b1; load_value = 16'd99;
        push("t5_run", 7, 1'b0, 1'b1);
        run_cycles(1);
        load_valid = 1'b0; start = 1'b1;
        push("t5_run", 6, 1'b0, 1'b1);
        run_cycles(1);
        start = 1'b0;
        push_run("t5_run", 5, 2);
        drain();
        stop = 1'b1;
        push("t5_stop", 2, 1'b0, 1'b0);
        drain();
        stop = 1'b0;
        chk("t5_expire_stop", 32'(expire_cnt), 32'd5);
        start = 1'b1;
        push("t5_restart", 8, 1'b0, 1'b1);
        run_cycles(1);
        start = 1'b0;
        push_run("t5_rerun", 7, 1);
        drain();
        stop = 1'b1;
        push("t5_stop_term", 1, 1'b0, 1'b0);
        drain();
        stop = 1'b0;
        chk("t5_expire_term", 32'(expire_cnt), 32'd5);

        // 6a: zero-length timer
        load_valid = 1'b1; load_value = 16'd0;
        push("t6_load0", 0, 1'b0, 1'b0);
        drain();
        load_valid = 1'b0; start = 1'b1; auto_reload = 1'b1;
        push("t6_zero_done", 0, 1'b1, 1'b1);
        run_cycles(1);
        start = 1'b0;
        push("t6_zero_idle", 0, 1'b0, 1'b0);
        drain();
        auto_reload = 1'b0;
        chk("t6_expire_zero", 32'(expire_cnt), 32'd6);

        // 6b: load+start same cycle with 2; stop in DONE beats auto-reload
        load_valid = 1'b1; load_value = 16'd2; start = 1'b1; auto_reload = 1'b1;
        push("t6_ldst", 2, 1'b0, 1'b1);
        run_cycles(1);
        load_valid = 1'b0; start = 1'b0;
        push("t6_run", 1, 1'b0, 1'b1);
        push("t6_done", 0, 1'b1, 1'b1);
        drain();
        stop = 1'b1;
        push("t6_stop_done", 0, 1'b0, 1'b0);
        drain();
        stop = 1'b0; auto_reload = 1'b0;
        chk("t6_expire_ldst", 32'(expire_cnt), 32'd7);

        // 6c: reset mid-count
        load_valid = 1'b1; load_value = 16'd9; start = 1'b1;
        push("t6_r_e0", 9, 1'b0, 1'b1);
        run_cycles(1);
        load_valid = 1'b0; start = 1'b0;
        push_run("t6_r_run", 8, 7);
        drain();
        reset = 1'b1;
        push("t6_reset", 0, 1'b0, 1'b0);
        drain();
        reset = 1'b0;
        chk("t6_reset_expire", 32'(expire_cnt), 32'd0);
        // reload_reg was cleared too: a bare start is a zero-length run
        start = 1'b1;
        push("t6_post_rst", 0, 1'b1, 1'b1);
        run_cycles(1);
        start = 1'b0;
        push("t6_post_idle", 0, 1'b0, 1'b0);
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
